alarm_ringer: RTL and testbench



---
 rtl/alarm_pkg.sv | 26 ++
 rtl/tick_gen.sv | 32 +++
 rtl/alarm_ringer.sv | 167 ++++++++++++++++
 tb/tb_alarm_ringer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared state encoding, default timing constants and a width helper
// for the alarm ringer and its tick prescaler.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RING,
    SNOOZE,
    DONE
  } state_t;

  localparam int unsigned DEF_TICK_DIV      = 100000;
  localparam int unsigned DEF_TICKS_PER_SEC = 500;
  localparam int unsigned DEF_BEEP_ON       = 125;
  localparam int unsigned DEF_BEEP_OFF      = 125;
  localparam int unsigned DEF_SNOOZE_SEC    = 300;
  localparam int unsigned DEF_TIMEOUT_SEC   = 60;

  localparam int SNOOZE_W = 9;

  // Width of a counter that must be able to hold the value itself.
  function automatic int cnt_w(input int unsigned value);
    return $clog2(value + 1);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
// Only reset clears it, so ring/snooze timing is never re-phased by it.
module tick_gen
  import alarm_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int W = cnt_w(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/alarm_ringer.sv
// Turns the level alarm-match into one ringing session per match period,
// with beep pattern, stop, snooze countdown and automatic ring timeout.
module alarm_ringer
  import alarm_pkg::*;
#(
  parameter int unsigned TICK_DIV      = DEF_TICK_DIV,
  parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int unsigned BEEP_ON       = DEF_BEEP_ON,
  parameter int unsigned BEEP_OFF      = DEF_BEEP_OFF,
  parameter int unsigned SNOOZE_SEC    = DEF_SNOOZE_SEC,
  parameter int unsigned TIMEOUT_SEC   = DEF_TIMEOUT_SEC
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                match,
  input  logic                stop_btn,
  input  logic                snooze_btn,
  output logic                buzzer,
  output logic                ringing,
  output logic                snoozing,
  output logic [SNOOZE_W-1:0] snooze_left
);

  localparam int SEC_W  = cnt_w(TICKS_PER_SEC);
  localparam int RING_W = cnt_w(TIMEOUT_SEC);
  localparam int BEEP_W = cnt_w(BEEP_ON + BEEP_OFF);

  localparam logic [SEC_W-1:0]    SEC_LAST   = SEC_W'(TICKS_PER_SEC - 1);
  localparam logic [RING_W-1:0]   RING_LAST  = RING_W'(TIMEOUT_SEC - 1);
  localparam logic [BEEP_W-1:0]   BEEP_LAST  = BEEP_W'(BEEP_ON + BEEP_OFF - 1);
  localparam logic [BEEP_W-1:0]   BEEP_HIGH  = BEEP_W'(BEEP_ON);
  localparam logic [SNOOZE_W-1:0] SNOOZE_LEN = SNOOZE_W'(SNOOZE_SEC);

  logic tick;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  // Sampled inputs plus one-cycle-older copies for rise detection.
  logic match_s, match_p;
  logic stop_s, stop_p;
  logic snooze_s, snooze_p;

  logic match_rise, stop_rise, snooze_rise;

  assign match_rise  = match_s  & ~match_p;
  assign stop_rise   = stop_s   & ~stop_p;
  assign snooze_rise = snooze_s & ~snooze_p;

  state_t              state, state_next;
  logic [SEC_W-1:0]    sec_cnt, sec_next;
  logic [RING_W-1:0]   ring_secs, ring_next;
  logic [BEEP_W-1:0]   beep_cnt, beep_next;
  logic [SNOOZE_W-1:0] left_next;
  logic                sec, entry, buzzer_next;

  assign sec   = tick && (sec_cnt == SEC_LAST);
  assign entry = (state_next != state);

  // NOTE: every signal written here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    sec_next    = sec_cnt;
    ring_next   = ring_secs;
    beep_next   = beep_cnt;
    left_next   = '0;
    buzzer_next = 1'b0;

    case (state)
      IDLE: begin
        if (match_rise) state_next = RING;
      end
      RING: begin
        if (stop_rise) begin
          state_next = DONE;
        end else if (snooze_rise) begin
          state_next = SNOOZE;
        end else if (sec && (ring_secs == RING_LAST)) begin
          state_next = DONE;
        end
      end
      SNOOZE: begin
        if (stop_rise) begin
          state_next = DONE;
        end else if (sec && (snooze_left == '0)) begin
          state_next = RING;
        end
      end
      DONE: begin
        // Wait for the match period to end so one minute rings only once.
        if (!match_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (entry) begin
      sec_next = '0;
    end else if (tick) begin
      sec_next = (sec_cnt == SEC_LAST) ? '0 : sec_cnt + SEC_W'(1);
    end

    if (entry) begin
      ring_next = '0;
    end else if ((state == RING) && sec) begin
      ring_next = ring_secs + RING_W'(1);
    end

    if (entry) begin
      beep_next = '0;
    end else if (tick) begin
      beep_next = (beep_cnt == BEEP_LAST) ? '0 : beep_cnt + BEEP_W'(1);
    end

    if (state_next == SNOOZE) begin
      if (entry) begin
        left_next = SNOOZE_LEN;
      end else if (sec) begin
        left_next = snooze_left - SNOOZE_W'(1);
      end else begin
        left_next = snooze_left;
      end
    end

    buzzer_next = (state_next == RING) && (beep_next < BEEP_HIGH);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      match_s     <= 1'b0;
      match_p     <= 1'b0;
      stop_s      <= 1'b0;
      stop_p      <= 1'b0;
      snooze_s    <= 1'b0;
      snooze_p    <= 1'b0;
      state       <= IDLE;
      sec_cnt     <= '0;
      ring_secs   <= '0;
      beep_cnt    <= '0;
      snooze_left <= '0;
      buzzer      <= 1'b0;
      ringing     <= 1'b0;
      snoozing    <= 1'b0;
    end else begin
      match_s     <= match;
      match_p     <= match_s;
      stop_s      <= stop_btn;
      stop_p      <= stop_s;
      snooze_s    <= snooze_btn;
      snooze_p    <= snooze_s;
      state       <= state_next;
      sec_cnt     <= sec_next;
      ring_secs   <= ring_next;
      beep_cnt    <= beep_next;
      snooze_left <= left_next;
      buzzer      <= buzzer_next;
      ringing     <= (state_next == RING);
      snoozing    <= (state_next == SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_ringer.sv
// Bench for alarm_ringer: session model built on elapsed-tick arithmetic,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_alarm_ringer;

  localparam int TD   = 4;
  localparam int TPS  = 5;
  localparam int BON  = 2;
  localparam int BOFF = 2;
  localparam int SN   = 3;
  localparam int TO   = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       match = 1'b0;
  logic       stop_btn = 1'b0;
  logic       snooze_btn = 1'b0;
  logic       buzzer, ringing, snoozing;
  logic [8:0] snooze_left;

  alarm_ringer #(
    .TICK_DIV     (TD),
    .TICKS_PER_SEC(TPS),
    .BEEP_ON      (BON),
    .BEEP_OFF     (BOFF),
    .SNOOZE_SEC   (SN),
    .TIMEOUT_SEC  (TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .match      (match),
    .stop_btn   (stop_btn),
    .snooze_btn (snooze_btn),
    .buzzer     (buzzer),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_left(snooze_left)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Edges are numbered from reset release; a tick lands on edge k when
  // k mod TD == TD-1. Everything timed is derived from ticks since the
  // edge on which the current phase began.
  typedef enum int {M_OFF, M_RING, M_SNOOZE, M_HUSH} phase_e;

  typedef struct packed {
    phase_e phase;
    int     entry;
    int     edge_n;
    logic   m1, m2, s1, s2, z1, z2;
  } model_t;

  typedef struct packed {
    logic       buzz;
    logic       ring;
    logic       snz;
    logic [8:0] left;
  } outs_t;

  model_t mdl = '0;

  function automatic int ticks_between(input int e, input int k);
    return (k + 1) / TD - (e + 1) / TD;
  endfunction

  function automatic model_t step(input model_t m, input logic mt,
                                  input logic st, input logic sz);
    model_t n;
    int     k, el;
    logic   m_rise, s_rise, z_rise;
    n      = m;
    k      = m.edge_n;
    el     = ticks_between(m.entry, k);
    m_rise = m.m1 & ~m.m2;
    s_rise = m.s1 & ~m.s2;
    z_rise = m.z1 & ~m.z2;
    case (m.phase)
      M_OFF: if (m_rise) begin n.phase = M_RING; n.entry = k; end
      M_RING: begin
        if (s_rise) n.phase = M_HUSH;
        else if (z_rise) begin n.phase = M_SNOOZE; n.entry = k; end
        else if (el >= TO * TPS) n.phase = M_HUSH;
      end
      M_SNOOZE: begin
        if (s_rise) n.phase = M_HUSH;
        else if (el >= (SN + 1) * TPS) begin n.phase = M_RING; n.entry = k; end
      end
      default: if (!m.m1) n.phase = M_OFF;
    endcase
    n.m2 = m.m1; n.m1 = mt;
    n.s2 = m.s1; n.s1 = st;
    n.z2 = m.z1; n.z1 = sz;
    n.edge_n = k + 1;
    return n;
  endfunction

  function automatic outs_t expected(input model_t m);
    outs_t o;
    int    el;
    o    = '0;
    el   = ticks_between(m.entry, m.edge_n - 1);
    o.ring = (m.phase == M_RING);
    o.snz  = (m.phase == M_SNOOZE);
    o.buzz = o.ring && ((el % (BON + BOFF)) < BON);
    if (o.snz) o.left = 9'(SN - el / TPS);
    return o;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) mdl <= '0;
    else       mdl <= step(mdl, match, stop_btn, snooze_btn);
  end

  always @(negedge clock) begin
    outs_t e;
    e = expected(mdl);
    check("model_ringing",     ringing,     e.ring);
    check("model_snoozing",    snoozing,    e.snz);
    check("model_buzzer",      buzzer,      e.buzz);
    check("model_snooze_left", snooze_left, e.left);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic ring_length(input string name);
    int dur;
    dur = 1;
    while (ringing && dur < 200) begin
      cyc(1);
      dur++;
    end
    dur--;
    check(name, int'(dur >= 77 && dur <= 80), 1);
  endtask

  initial begin
    int   cnt;
    logic saw;

    cyc(3);
    reset = 1'b0;
    cyc(2);
    check("reset_ringing",  ringing,     0);
    check("reset_snoozing", snoozing,    0);
    check("reset_buzzer",   buzzer,      0);
    check("reset_left",     snooze_left, 0);

    // Ring and timeout
    match = 1'b1;
    cyc(1);
    check("ring_latency_early", ringing, 0);
    cyc(1);
    check("ring_latency", ringing, 1);
    check("ring_buzzer_on", buzzer, 1);
    cyc(1);
    ring_length("timeout_length");
    cyc(40);
    check("no_rering_same_match", ringing, 0);
    match = 1'b0;
    cyc(3);

    // Stop, then a fresh match rings again
    match = 1'b1;
    cyc(12);
    stop_btn = 1'b1;
    cyc(2);
    check("stop_ringing", ringing, 0);
    check("stop_buzzer",  buzzer,  0);
    stop_btn = 1'b0;
    cyc(3);
    match = 1'b0;
    cyc(3);
    match = 1'b1;
    cyc(2);
    check("rering_after_idle", ringing, 1);

    // Snooze countdown and return to a full ring
    cyc(5);
    snooze_btn = 1'b1;
    cyc(2);
    check("snooze_entered", snoozing,    1);
    check("snooze_start",   snooze_left, 3);
    check("snooze_quiet",   buzzer,      0);
    snooze_btn = 1'b0;
    cnt = 0;
    while (!ringing && cnt < 200) begin
      cyc(1);
      cnt++;
    end
    check("snooze_return",        ringing, 1);
    check("snooze_return_buzzer", buzzer,  1);
    check("snooze_length", int'(cnt >= 77 && cnt <= 80), 1);
    cyc(1);
    ring_length("timeout_after_snooze");
    match = 1'b0;
    cyc(4);

    // Coincident stop and snooze: stop wins
    match = 1'b1;
    cyc(6);
    stop_btn = 1'b1;
    snooze_btn = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      cyc(1);
      if (snoozing) saw = 1'b1;
    end
    check("coincident_no_snooze", saw,     0);
    check("coincident_done",      ringing, 0);
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
    match = 1'b0;
    cyc(4);

    // Snooze held from before the ring is not a rise
    snooze_btn = 1'b1;
    cyc(3);
    match = 1'b1;
    cyc(12);
    check("held_snooze_ignored", snoozing, 0);
    check("held_snooze_ringing", ringing,  1);
    snooze_btn = 1'b0;
    stop_btn = 1'b1;
    cyc(2);
    stop_btn = 1'b0;
    match = 1'b0;
    cyc(4);

    // Reset mid-snooze
    match = 1'b1;
    cyc(5);
    snooze_btn = 1'b1;
    cyc(2);
    snooze_btn = 1'b0;
    cnt = 0;
    while (snooze_left != 9'd2 && cnt < 100) begin
      cyc(1);
      cnt++;
    end
    check("reach_left_2", snooze_left, 2);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_reset_ringing",  ringing,     0);
    check("async_reset_snoozing", snoozing,    0);
    check("async_reset_buzzer",   buzzer,      0);
    check("async_reset_left",     snooze_left, 0);
    match = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(3);
    check("post_reset_ringing",  ringing,  0);
    check("post_reset_snoozing", snoozing, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) match = ~match;
      stop_btn   = ($urandom_range(0, 149) == 0) ? 1'b1
                 : (stop_btn && ($urandom_range(0, 3) != 0));
      snooze_btn = ($urandom_range(0, 59) == 0) ? 1'b1
                 : (snooze_btn && ($urandom_range(0, 3) != 0));
      reset      = ($urandom_range(0, 1499) == 0);
      cyc(1);
    end
    reset = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
